lap_timer_bank: RTL and testbench
=================================

# lap_timer_bank

Multi-channel elapsed-time counter bank for the BubbleDrive8 timing and temperature-sense path. One shared prescaler divides MCLK down to a tick rate. CH independent channels count ticks, each with its own start/pause/clear control and saturating overflow. It is the parametrised successor of the single-channel seconds counter: configurable width, tick rate and channel count, with pause/resume and an optional synchronous snapshot of all channels.

## Interface
Parameters:
- CLOCK_HZ, 48000000, MCLK frequency.
- TICK_HZ, 1, count rate. DIV = CLOCK_HZ/TICK_HZ must be an integer ≥ 2.
- CH, 4, number of channels (1..16).
- WIDTH, 16, bits per channel count (2..32).

Ports:
- MCLK  in  1  clock. Reset nRESET, synchronous, active-low; clock MCLK.
- nRESET  in  1  synchronous active-low reset of prescaler and all channels.
- CH_START  in  CH  per-channel start/resume strobe, active-high.
- CH_PAUSE  in  CH  per-channel pause strobe, active-high.
- CH_CLEAR  in  CH  per-channel clear strobe, active-high.
- TIME  out  CH*WIDTH  packed counts; channel n at [n*WIDTH +: WIDTH].
- RUNNING  out  CH  channel n is in RUN.
- OVFL  out  CH  channel n has saturated.
- TICK  out  1  one-cycle prescaler tick pulse.
- CAPTURE  in  1  snapshot strobe; only with LAP_TIMER_CAPTURE_EN.
- CAPT  out  CH*WIDTH  snapshot bus; only with LAP_TIMER_CAPTURE_EN.
- CAPT_VALID  out  1  snapshot-updated pulse; only with LAP_TIMER_CAPTURE_EN.

## Operation
- Prescaler:
  - Counts 0..DIV-1 and wraps. It is free-running; channel controls do not affect it.
  - TICK is registered and asserts for the one cycle after the prescaler reaches DIV-1.
  - Period is exactly DIV cycles.
- Channel FSM states: IDLE, RUN, HOLD, SAT.
  - IDLE: count = 0. CH_START → RUN.
  - RUN: on TICK, count + 1. If count = 2^WIDTH−1 at a TICK: count stays, OVFL ← 1, go to SAT. CH_PAUSE → HOLD.
  - HOLD: count frozen. CH_START → RUN.
  - SAT: count frozen at all-ones, OVFL = 1. Only CH_CLEAR exits.
  - Any state: CH_CLEAR → IDLE, count ← 0, OVFL ← 0.
- Priority per channel: nRESET > CH_CLEAR > CH_PAUSE > CH_START > TICK increment.
- Simultaneous events:
  - A TICK in the same cycle as a CH_START from IDLE/HOLD is not counted.
  - A TICK in the same cycle as CH_PAUSE in RUN is not counted.
  - A TICK in the same cycle as CH_CLEAR is discarded.
- Channels are fully independent. Several strobes on different channels in one cycle are all honoured.
- Count arithmetic is unsigned WIDTH-bit and never wraps.

## Timing
- Reset values: TIME = 0, RUNNING = 0, OVFL = 0, TICK = 0, CAPT = 0, CAPT_VALID = 0. Prescaler = 0. All channels in IDLE.
- First TICK pulse is the DIV-th cycle after the first cycle with nRESET high.
- Strobe latency: a strobe sampled at edge k is reflected in RUNNING/TIME/OVFL after edge k.
- TIME increments on the edge where TICK is high, so it is visible one cycle after the TICK pulse.
- Strobes are level-sampled every cycle. A strobe held for several cycles acts as repeated strobes, which are idempotent.
- nRESET mid-count aborts everything within one edge and also restarts the prescaler phase.

## Configuration
- Macro: LAP_TIMER_CAPTURE_EN.
- Defined:
  - CAPTURE, CAPT and CAPT_VALID exist.
  - CAPTURE high at edge k copies the TIME value present before edge k into CAPT. This is the value excluding any increment made on edge k.
  - CAPT_VALID is high for the cycle after edge k.
  - CAPT holds until the next CAPTURE or reset.
  - CAPTURE coincident with CH_CLEAR captures the pre-clear value.
- Undefined: those ports and registers are absent; channel behaviour is identical.

## Test plan
Bench parameters: CLOCK_HZ=10, TICK_HZ=1 (DIV=10), CH=2, WIDTH=4.
- Reset release, CH_START[0] strobe → RUNNING = 01; TICK every 10 cycles; TIME[3:0] counts 1, 2, 3… one cycle after each TICK; TIME[7:4] stays 0.
- Ch0 runs 5 ticks, CH_PAUSE[0], wait 30 cycles, CH_START[0] → TIME[3:0] holds 5 while paused, then 6 after the next TICK.
- Ch1 runs 15 ticks → TIME[7:4] = 15, OVFL[1] = 0; 16th tick → TIME[7:4] stays 15, OVFL[1] = 1, RUNNING[1] = 0; CH_CLEAR[1] → 0, 0.
- CH_START[0] asserted in the TICK cycle → count stays 0 for that tick. CH_CLEAR and CH_PAUSE on the same cycle → IDLE, TIME = 0.
- nRESET low for 1 cycle mid-count → all outputs 0; next TICK exactly 10 cycles after release.
- With LAP_TIMER_CAPTURE_EN: ch0 = 7, ch1 = 3, CAPTURE → CAPT = 8'h37, CAPT_VALID for 1 cycle; TIME continues counting while CAPT holds 8'h37.

Source files
------------

// File: rtl/lap_timer_bank.sv
// lap_timer_bank: shared prescaler plus CH saturating elapsed-tick counters with start/pause/clear.
// Define LAP_TIMER_CAPTURE_EN to add the CAPTURE/CAPT/CAPT_VALID snapshot of all channels.
module lap_timer_bank #(
  parameter int CLOCK_HZ = 48000000,
  parameter int TICK_HZ  = 1,
  parameter int CH       = 4,
  parameter int WIDTH    = 16
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  input  logic [CH-1:0]         CH_START,
  input  logic [CH-1:0]         CH_PAUSE,
  input  logic [CH-1:0]         CH_CLEAR,
`ifdef LAP_TIMER_CAPTURE_EN
  input  logic                  CAPTURE,
  output logic [CH*WIDTH-1:0]   CAPT,
  output logic                  CAPT_VALID,
`endif
  output logic [CH*WIDTH-1:0]   TIME,
  output logic [CH-1:0]         RUNNING,
  output logic [CH-1:0]         OVFL,
  output logic                  TICK
);
  localparam int DIV = CLOCK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, SAT} state_t;
  logic [PW-1:0] pcnt;
  always_ff @(posedge MCLK)
    if (!nRESET) begin
      pcnt <= '0;
      TICK <= 1'b0;
    end else begin
      pcnt <= (pcnt == PW'(DIV - 1)) ? '0 : pcnt + 1'b1;
      TICK <= pcnt == PW'(DIV - 1);
    end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t st;
    logic [WIDTH-1:0] cnt;
    // each else-if level encodes the strobe priority, so a coincident TICK is dropped
    always_ff @(posedge MCLK)
      if (!nRESET || CH_CLEAR[c]) begin
        st  <= IDLE;
        cnt <= '0;
      end else if (CH_PAUSE[c])
        st <= (st == RUN) ? HOLD : st;
      else if (CH_START[c] && (st == IDLE || st == HOLD))
        st <= RUN;
      else if (TICK && st == RUN) begin
        if (&cnt) st <= SAT;
        else cnt <= cnt + 1'b1;
      end
    assign TIME[c*WIDTH +: WIDTH] = cnt;
    assign RUNNING[c] = st == RUN;
    assign OVFL[c]    = st == SAT;
  end
`ifdef LAP_TIMER_CAPTURE_EN
  always_ff @(posedge MCLK)
    if (!nRESET) begin
      CAPT       <= '0;
      CAPT_VALID <= 1'b0;
    end else begin
      CAPT       <= CAPTURE ? TIME : CAPT;
      CAPT_VALID <= CAPTURE;
    end
`endif
endmodule

// File: tb/tb_lap_timer_bank.sv
// tb_lap_timer_bank: directed bench for lap_timer_bank with DIV=10, CH=2, WIDTH=4.
module tb_lap_timer_bank;
  logic       MCLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [1:0] CH_START = '0, CH_PAUSE = '0, CH_CLEAR = '0;
  logic [7:0] TIME;
  logic [1:0] RUNNING, OVFL;
  logic       TICK;
  int checks = 0, failures = 0, n;
`ifdef LAP_TIMER_CAPTURE_EN
  logic       CAPTURE = 1'b0;
  logic [7:0] CAPT;
  logic       CAPT_VALID;
`endif

  lap_timer_bank #(.CLOCK_HZ(10), .TICK_HZ(1), .CH(2), .WIDTH(4)) dut (
    .MCLK(MCLK), .nRESET(nRESET),
    .CH_START(CH_START), .CH_PAUSE(CH_PAUSE), .CH_CLEAR(CH_CLEAR),
`ifdef LAP_TIMER_CAPTURE_EN
    .CAPTURE(CAPTURE), .CAPT(CAPT), .CAPT_VALID(CAPT_VALID),
`endif
    .TIME(TIME), .RUNNING(RUNNING), .OVFL(OVFL), .TICK(TICK)
  );

  always #5 MCLK = ~MCLK;

  task automatic cyc(input int k);
    repeat (k) @(negedge MCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick_high();
    int k = 0;
    while (TICK !== 1'b1 && k < 15) begin
      cyc(1);
      k++;
    end
    chk("tick_timeout", {31'd0, TICK}, 32'd1);
  endtask

  task automatic to_tick();
    wait_tick_high();
    cyc(1);
  endtask

  task automatic count_to_tick(output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (TICK !== 1'b1 && cnt < 20);
  endtask

  initial begin
    cyc(3);
    chk("rst_time", TIME, 0);
    chk("rst_running", RUNNING, 0);
    chk("rst_ovfl", OVFL, 0);
    chk("rst_tick", TICK, 0);
`ifdef LAP_TIMER_CAPTURE_EN
    chk("rst_capt", CAPT, 0);
    chk("rst_capt_valid", CAPT_VALID, 0);
`endif
    nRESET = 1'b1; CH_START = 2'b01;
    cyc(1);
    CH_START = '0;
    chk("start_running", RUNNING, 2'b01);
    n = 1;
    while (TICK !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first_tick_cycle", n, 10);
    chk("time_before_inc", TIME, 8'h00);
    cyc(1);
    chk("time_after_tick1", TIME, 8'h01);
    chk("tick_one_cycle", TICK, 0);
    cyc(9);
    chk("tick_period", TICK, 1);
    cyc(1);
    chk("time_after_tick2", TIME, 8'h02);
    to_tick(); to_tick(); to_tick();
    chk("ch0_five", TIME, 8'h05);
    CH_PAUSE = 2'b01;
    cyc(1);
    CH_PAUSE = '0;
    chk("pause_running", RUNNING, 2'b00);
    cyc(30);
    chk("paused_hold", TIME, 8'h05);
    CH_START = 2'b01;
    cyc(1);
    CH_START = '0;
    chk("resume_running", RUNNING, 2'b01);
    to_tick();
    chk("resume_six", TIME, 8'h06);
    CH_PAUSE = 2'b01; CH_START = 2'b10;
    cyc(1);
    CH_PAUSE = '0; CH_START = '0;
    chk("multi_strobe", RUNNING, 2'b10);
    repeat (15) to_tick();
    chk("ch1_fifteen", TIME, 8'hF6);
    chk("ch1_no_ovfl", OVFL, 2'b00);
    to_tick();
    chk("ch1_sat_time", TIME, 8'hF6);
    chk("ch1_sat_ovfl", OVFL, 2'b10);
    chk("ch1_sat_running", RUNNING, 2'b00);
    CH_START = 2'b10;
    to_tick();
    CH_START = '0;
    chk("sat_ignores_start", {OVFL, TIME}, {2'b10, 8'hF6});
    CH_CLEAR = 2'b11;
    cyc(1);
    CH_CLEAR = '0;
    chk("clear_time", TIME, 8'h00);
    chk("clear_ovfl", OVFL, 2'b00);
    wait_tick_high();
    CH_START = 2'b01;
    cyc(1);
    CH_START = '0;
    chk("start_on_tick_time", TIME, 8'h00);
    chk("start_on_tick_run", RUNNING, 2'b01);
    to_tick();
    chk("start_on_tick_next", TIME, 8'h01);
    CH_CLEAR = 2'b01; CH_PAUSE = 2'b01;
    cyc(1);
    CH_CLEAR = '0; CH_PAUSE = '0;
    chk("clr_pause_time", TIME, 8'h00);
    chk("clr_pause_run", RUNNING, 2'b00);
    CH_START = 2'b11;
    cyc(1);
    CH_START = '0;
    to_tick(); to_tick();
    chk("both_two", TIME, 8'h22);
    cyc(3);
    nRESET = 1'b0;
    cyc(1);
    nRESET = 1'b1;
    chk("midrst_all", {TIME, RUNNING, OVFL, TICK}, 13'd0);
    count_to_tick(n);
    chk("midrst_tick_cycle", n, 10);
`ifdef LAP_TIMER_CAPTURE_EN
    cyc(1);
    CH_START = 2'b01;
    cyc(1);
    CH_START = '0;
    repeat (4) to_tick();
    CH_START = 2'b10;
    cyc(1);
    CH_START = '0;
    repeat (3) to_tick();
    chk("cap_pre_time", TIME, 8'h37);
    CAPTURE = 1'b1;
    cyc(1);
    CAPTURE = 1'b0;
    chk("capt_value", CAPT, 8'h37);
    chk("capt_valid_hi", CAPT_VALID, 1);
    cyc(1);
    chk("capt_valid_lo", CAPT_VALID, 0);
    to_tick();
    chk("cap_time_moves", TIME, 8'h48);
    chk("capt_holds", CAPT, 8'h37);
    CAPTURE = 1'b1; CH_CLEAR = 2'b11;
    cyc(1);
    CAPTURE = 1'b0; CH_CLEAR = '0;
    chk("capt_pre_clear", CAPT, 8'h48);
    chk("capt_clear_time", TIME, 8'h00);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
